// File: rtl/traffic_rr.sv
// traffic_rr: N-approach traffic-light controller with round-robin arbitration.
// Exactly one approach holds right-of-way at a time. Green length is sensor-driven,
// bounded by GREEN_MIN / GREEN_MAX. It is followed by a fixed yellow phase and an
// optional all-red clearance phase. The next approach is the first requester found
// after the current one in circular order.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   T      - per-approach sensor, 1 = vehicle waiting (clock-aligned, no synchroniser)
//   L      - per-approach light: 0 green, 1 yellow, 2 red
//   active - approach currently in green/yellow; held through all-red
//   phase  - 0 GREEN, 1 YELLOW, 2 ALLRED
module traffic_rr #(
    parameter int unsigned N_DIR     = 4,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 10,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_DIR-1:0]           T,
    output logic [N_DIR-1:0][1:0]      L,
    output logic [$clog2(N_DIR)-1:0]   active,
    output logic [1:0]                 phase
);

    localparam int unsigned ActW    = $clog2(N_DIR);
    localparam int unsigned MaxGy   = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int unsigned MaxT    = (MaxGy > ALLRED_T) ? MaxGy : ALLRED_T;
    localparam int unsigned CntW    = $clog2(MaxT + 1);

    localparam logic [CntW-1:0] GreenMinLast = CntW'(GREEN_MIN - 1);
    localparam logic [CntW-1:0] GreenMaxLast = CntW'(GREEN_MAX - 1);
    localparam logic [CntW-1:0] YellowLast   = CntW'(YELLOW_T - 1);
    localparam logic [CntW-1:0] AllredLast   = CntW'((ALLRED_T == 0) ? 0 : ALLRED_T - 1);

    typedef enum logic [1:0] {
        StGreen  = 2'd0,
        StYellow = 2'd1,
        StAllred = 2'd2
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [ActW-1:0]    active_q, active_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [ActW-1:0]    next_dir;
    logic               others;
    int unsigned        best_dist;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= StGreen;
            active_q <= '0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any request from an approach other than the active one
    always_comb begin
        others = 1'b0;
        for (int unsigned i = 0; i < N_DIR; i++) begin
            if (T[i] && (ActW'(i) != active_q)) begin
                others = 1'b1;
            end
        end
    end

    // Round-robin pick: smallest circular distance after active wins; active itself
    // sits at distance N_DIR-1, so it is considered last. No requester -> active+1.
    always_comb begin
        best_dist = N_DIR;
        next_dir  = ActW'((32'(active_q) + 1) % N_DIR);
        for (int unsigned i = 0; i < N_DIR; i++) begin
            if (T[i] && (((i + N_DIR - 1 - 32'(active_q)) % N_DIR) < best_dist)) begin
                best_dist = (i + N_DIR - 1 - 32'(active_q)) % N_DIR;
                next_dir  = ActW'(i);
            end
        end
    end

    // Next-state logic
    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        unique case (phase_q)
            StGreen: begin
                if ((cnt_q >= GreenMinLast) && others
                    && (!T[active_q] || (cnt_q >= GreenMaxLast))) begin
                    phase_d = StYellow;
                    cnt_d   = '0;
                end else if (cnt_q < GreenMaxLast) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StYellow: begin
                if (cnt_q == YellowLast) begin
                    cnt_d = '0;
                    if (ALLRED_T == 0) begin
                        phase_d  = StGreen;
                        active_d = next_dir;
                    end else begin
                        phase_d = StAllred;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAllred: begin
                if (cnt_q == AllredLast) begin
                    phase_d  = StGreen;
                    active_d = next_dir;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                phase_d  = StGreen;
                active_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        for (int unsigned i = 0; i < N_DIR; i++) begin
            L[i] = 2'd2;
            if (ActW'(i) == active_q) begin
                if (phase_q == StGreen) begin
                    L[i] = 2'd0;
                end else if (phase_q == StYellow) begin
                    L[i] = 2'd1;
                end
            end
        end
        active = active_q;
        phase  = phase_q;
    end

endmodule

// File: tb/tb_traffic_rr.sv
// Self-checking bench for traffic_rr (default parameters). A behavioural model
// tracks phase, active approach and unbounded elapsed time in phase; a compare
// process checks every DUT output against it on every falling edge. Directed
// scenarios add literal expectations; a randomized run follows.
module tb_traffic_rr;

    localparam int N    = 4;
    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YEL  = 2;
    localparam int AR   = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       t   = 4'b0000;
    logic [3:0][1:0]  l_out;
    logic [1:0]       act_out;
    logic [1:0]       ph_out;

    int vectors     = 0;
    int miscompares = 0;

    int m_phase = 0;
    int m_act   = 0;
    int m_el    = 0;
    int tin;

    int tr_ph  [0:99];
    int tr_act [0:99];
    int tr_l   [0:99];

    assign tin = int'(t);

    traffic_rr dut (
        .clk    (clk),
        .rst    (rst),
        .T      (t),
        .L      (l_out),
        .active (act_out),
        .phase  (ph_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // First requester after act in circular order, act itself last; none -> act+1
    function automatic int pick(input int act, input int req);
        for (int k = 1; k <= N; k++) begin
            if (((req >> ((act + k) % N)) & 1) != 0) return (act + k) % N;
        end
        return (act + 1) % N;
    endfunction

    function automatic int exp_lights(input int ph, input int act);
        int v = 0;
        for (int i = 0; i < N; i++) begin
            if (ph == 2 || i != act) v |= 2 << (2 * i);
            else v |= ph << (2 * i);
        end
        return v;
    endfunction

    // Behavioural reference
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_act   <= 0;
            m_el    <= 0;
        end else begin
            case (m_phase)
                0: begin
                    if (m_el >= GMIN - 1 && (tin & ~(1 << m_act) & 15) != 0
                        && (((tin >> m_act) & 1) == 0 || m_el >= GMAX - 1)) begin
                        m_phase <= 1;
                        m_el    <= 0;
                    end else begin
                        m_el <= m_el + 1;
                    end
                end
                1: begin
                    if (m_el == YEL - 1) begin
                        m_el <= 0;
                        if (AR == 0) begin
                            m_phase <= 0;
                            m_act   <= pick(m_act, tin);
                        end else begin
                            m_phase <= 2;
                        end
                    end else begin
                        m_el <= m_el + 1;
                    end
                end
                default: begin
                    if (m_el == AR - 1) begin
                        m_phase <= 0;
                        m_act   <= pick(m_act, tin);
                        m_el    <= 0;
                    end else begin
                        m_el <= m_el + 1;
                    end
                end
            endcase
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (!rst) begin
            check("lights", int'(l_out), exp_lights(m_phase, m_act));
            check("active", int'(act_out), m_act);
            check("phase", int'(ph_out), m_phase);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Record n samples, one per falling edge, starting at the current one
    task automatic trace(input int n, input bit drop_on_yellow);
        for (int k = 0; k < n; k++) begin
            tr_ph[k]  = int'(ph_out);
            tr_act[k] = int'(act_out);
            tr_l[k]   = int'(l_out);
            if (drop_on_yellow && ph_out == 2'd1) t = 4'b0000;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        // Idle: no requests, dir 0 stays green
        t = 4'b0000;
        do_reset();
        trace(50, 1'b0);
        for (int k = 0; k < 50; k += 7) check("idle_lights", tr_l[k], 'hA8);
        check("idle_phase", tr_ph[49], 0);
        check("idle_active", tr_act[49], 0);

        // Single request on dir 2
        do_reset();
        t = 4'b0100;
        trace(10, 1'b0);
        check("t2_green_last", tr_ph[3], 0);
        check("t2_yellow0", tr_ph[4], 1);
        check("t2_yellow1", tr_ph[5], 1);
        check("t2_allred", tr_ph[6], 2);
        check("t2_green_ph", tr_ph[7], 0);
        check("t2_green_act", tr_act[7], 2);
        check("t2_lights", tr_l[7], 'h8A);

        // Dir 0 and 1 held: max green
        do_reset();
        t = 4'b0011;
        trace(15, 1'b0);
        check("max_green9", tr_ph[9], 0);
        check("max_yellow", tr_ph[10], 1);
        check("max_allred", tr_ph[12], 2);
        check("max_next_ph", tr_ph[13], 0);
        check("max_next_act", tr_act[13], 1);

        // All requesting: rotation 0,1,2,3,0 with 13-cycle period
        do_reset();
        t = 4'b1111;
        trace(80, 1'b0);
        for (int j = 0; j < 5; j++) begin
            check("rr_act", tr_act[13 * j], j % N);
            check("rr_green_end", tr_ph[13 * j + 9], 0);
            if (j < 4) begin
                check("rr_yellow", tr_ph[13 * j + 10], 1);
                check("rr_allred", tr_ph[13 * j + 12], 2);
            end
        end

        // T[3] withdrawn when yellow starts: fallback to active+1
        do_reset();
        t = 4'b1000;
        trace(10, 1'b1);
        check("fb_yellow", tr_ph[4], 1);
        check("fb_next_ph", tr_ph[7], 0);
        check("fb_next_act", tr_act[7], 1);

        // Reset pulse mid-yellow of dir 2
        do_reset();
        t = 4'b0100;
        waited = 0;
        while (act_out != 2'd2 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        t = 4'b0001;
        while (!(ph_out == 2'd1 && act_out == 2'd2) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("mid_pre_phase", int'(ph_out), 1);
        check("mid_pre_active", int'(act_out), 2);
        rst = 1'b1;
        #1;
        check("mid_rst_lights", int'(l_out), 'hA8);
        check("mid_rst_phase", int'(ph_out), 0);
        check("mid_rst_active", int'(act_out), 0);
        #2;
        rst = 1'b0;
        t = 4'b0100;
        trace(10, 1'b0);
        check("mid_resume_act", tr_act[7], 2);

        // Randomized run with occasional async reset pulses
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) t = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #3;
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_rr.md
# traffic_rr

Parametrised N-approach traffic-light controller, the successor to the two-road `traffic` block. It serves `N_DIR` approaches, and exactly one approach holds right-of-way at a time. Green duration is sensor-driven and bounded by minimum and maximum times, followed by timed yellow and all-red clearance phases. The next approach is chosen round-robin among the requesting approaches. It sits directly between the road sensors and the lamp drivers; the light encoding matches the existing `colors` enum (green=0, yellow=1, red=2).

## Interface
- `N_DIR`, 4, number of approaches (≥2)
- `GREEN_MIN`, 4, minimum green cycles (≥1)
- `GREEN_MAX`, 10, maximum green cycles while others wait (≥`GREEN_MIN`)
- `YELLOW_T`, 2, yellow cycles (≥1)
- `ALLRED_T`, 1, all-red clearance cycles (0 = skip phase)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `T`  in  `N_DIR`  traffic sensor per approach; 1 = vehicle waiting
- `L`  out  `[N_DIR-1:0][1:0]`  light per approach: 0 green, 1 yellow, 2 red; 3 is never driven
- `active`  out  `$clog2(N_DIR)`  index of the approach in green/yellow; holds the last value during all-red
- `phase`  out  2  0 GREEN, 1 YELLOW, 2 ALLRED

## Operation
- State: `phase`, `active`, and phase counter `cnt`. `cnt` is cleared on every phase entry and increments each cycle.
- Counter width: `$clog2(max(GREEN_MAX,YELLOW_T,ALLRED_T)+1)`. In GREEN the counter saturates at `GREEN_MAX-1` and never wraps.
- `others` = OR of `T[i]` for all i ≠ `active`.
- GREEN: `L[active]`=0 and all other approaches red. Leave for YELLOW when `cnt ≥ GREEN_MIN-1`, `others`=1, and either `T[active]`=0 or `cnt ≥ GREEN_MAX-1`.
- GREEN with no other request: stay green indefinitely, regardless of `T[active]`.
- YELLOW: `L[active]`=1 and all others red. After exactly `YELLOW_T` cycles, go to ALLRED; if `ALLRED_T`=0, go straight to GREEN of the next approach.
- ALLRED: all approaches red. After exactly `ALLRED_T` cycles, go to GREEN of the next approach.
- Next-approach selection happens on the exit edge of the final clearance phase, using `T` sampled that cycle.
  - Search order is `active+1`, `active+2`, … mod `N_DIR`, then `active` itself; the first approach with `T`=1 wins.
  - If no approach is requesting, the next approach is `active+1` mod `N_DIR`.
- `T` is used synchronously with no internal synchroniser; the bench and upstream logic drive it clock-aligned.
- Lights are decoded from registered state only, so no combinational path exists from `T` to `L`.
- Sensor changes during YELLOW or ALLRED never abort or extend those phases.

## Timing
- Reset (async assert, takes effect immediately without a clock edge):
  - `phase`=GREEN, `active`=0, `cnt`=0.
  - `L[0]`=0 and `L[i]`=2 for every i≠0.
- Reset deassert: the first rising edge after deassert is GREEN cycle 0.
- Green time: minimum `GREEN_MIN` cycles; with competing requests, maximum `GREEN_MAX` cycles.
- Yellow time is exactly `YELLOW_T` cycles; all-red time is exactly `ALLRED_T` cycles.
- Decision latency: a request present at the `GREEN_MIN-1` edge yields yellow on the next cycle.
- Reset asserted mid-phase (any phase): the block returns to the reset state immediately. No partial yellow or all-red completes.
- At any instant, at most one approach is non-red.

## Test plan
(Defaults, 10 ns clock.)
- Reset, all `T`=0 for 50 cycles -> `L[0]`=0, `L[1..3]`=2 throughout; `phase`=0; `active`=0.
- `T[2]`=1 held after reset release -> `L[0]` green for 4 cycles, yellow for 2, all red for 1, then `L[2]`=0 and `active`=2; `L[1]` and `L[3]` stay red.
- `T[0]`=1 and `T[1]`=1 held -> `L[0]` green for 10 cycles (max), yellow for 2, all-red for 1, then `active`=1.
- All `T`=1 held for 80 cycles -> green order 0,1,2,3,0; each green lasts 10 cycles; each gap is exactly 3 cycles.
- `T[3]` pulsed during dir-0 green until YELLOW begins, then 0 -> next green is `active`=1 (fallback to `active+1`), not 3.
- `rst` pulsed for 3 ns mid-YELLOW of dir 2 -> within the same cycle `L[0]`=0, others 2, `phase`=0; normal sequencing resumes after release.
